// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the pc, reads instruction memory and buffers
// {pc, instr} pairs toward decode; redirects flush and restart, misaligned targets trap.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misaligned
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {ST_RUN, ST_ERROR} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic               misaligned_q, misaligned_d;
  entry_t             mem_q [DEPTH];
  logic               push;
  logic               pop;
  entry_t             wr_entry;

  assign imem_address = {2'b00, pc_q[31:2]};
  assign out_valid    = (cnt_q != '0);
  assign out_pc       = mem_q[rd_q].pc;
  assign out_instr    = mem_q[rd_q].instr;
  assign misaligned   = misaligned_q;
  assign wr_entry     = '{pc: pc_q, instr: imem_data};

  // Next-state: a redirect flushes and wins over push/pop; ERROR only drains.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    misaligned_d = misaligned_q;
    push         = 1'b0;
    pop          = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          cnt_d = '0;
          rd_d  = '0;
          wr_d  = '0;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_d = redirect_pc;
          end else begin
            misaligned_d = 1'b1;
            state_d      = ST_ERROR;
          end
        end else begin
          // Full is judged on the current count, so a same-cycle pop does not free a slot.
          push = fetch_enable && (cnt_q != CNT_W'(DEPTH));
          pop  = out_valid && out_ready;
        end
      end
      ST_ERROR: begin
        pop = out_valid && out_ready;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (push) begin
      wr_d = wr_q + PTR_W'(1);
      pc_d = pc_q + 32'd4;
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    if (push || pop) begin
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      cnt_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      misaligned_q <= misaligned_d;
      if (push) begin
        mem_q[wr_q] <= wr_entry;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core. Holds the program counter, drives the word address into the instruction memory, captures the combinationally returned instruction word, and buffers `{pc, instr}` pairs in a small queue toward decode with a valid/ready handshake. Branch/jump redirects from execute flush the queue and restart fetch at the target. Misaligned targets raise a sticky error.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- `DEPTH`, 2, queue entries; power of two, ≥2.

- `clock`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `fetch_enable`  in  1  1 = fetch allowed this cycle
- `imem_address`  out  32  word address to instruction memory = `{2'b00, pc[31:2]}`
- `imem_data`  in  32  instruction word, combinational same-cycle response to `imem_address`
- `redirect_valid`  in  1  branch/jump taken this cycle
- `redirect_pc`  in  32  byte target PC
- `out_valid`  out  1  queue head valid to decode
- `out_ready`  in  1  decode accepts head
- `out_instr`  out  32  head instruction word
- `out_pc`  out  32  head byte PC
- `misaligned`  out  1  sticky: redirect target had `redirect_pc[1:0] != 0`

## Operation
- States: RUN, ERROR. Reset → RUN.
- Reset (synchronous): pc = RESET_PC, queue count = 0, read/write pointers = 0, state = RUN, `misaligned` = 0, `out_valid` = 0. `out_instr`/`out_pc` reflect the head entry (don't-care while `out_valid` = 0).
- `imem_address` is driven combinationally from the pc register at all times, including in ERROR.
- `out_valid` = (count != 0). `out_instr`/`out_pc` = head entry, combinational from the queue.
- Priority per cycle, in RUN: redirect > push/pop.
- Redirect (`redirect_valid` = 1):
  - The queue is flushed (count, pointers = 0). No push; no pop is counted, even if `out_valid & out_ready`.
  - If `redirect_pc[1:0] == 0`: pc <= `redirect_pc`.
  - Otherwise: pc is unchanged, `misaligned` <= 1, and state <= ERROR.
- Push: `fetch_enable` & count < DEPTH & no redirect.
  - Writes `{pc, imem_data}` at the write pointer and sets pc <= pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Pop: `out_valid` & `out_ready` & no redirect; advances the read pointer.
- Full is judged on the current count. When count == DEPTH, no push occurs even if a pop happens in the same cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- ERROR:
  - No push and no pc change. Redirect is ignored.
  - Pops still drain the queue. The queue is empty on entry because of the flush.
  - `misaligned` holds 1. Only `reset` leaves ERROR.
- Reset asserted mid-operation overrides everything: the queue contents are dropped and pc = RESET_PC on the next edge.

## Timing
- Reset released before edge E0: the first push occurs at edge E1 (pc = RESET_PC), `out_valid` is 1 after E1, and pc = RESET_PC+4.
- Fetch→decode latency: 1 cycle. An instruction addressed in cycle N is visible at `out_instr` in cycle N+1 when the queue was empty.
- Redirect sampled at edge N:
  - After N: pc = target and the queue is empty (`out_valid` = 0).
  - At edge N+1: the target is pushed.
  - After N+1: `out_valid` = 1 with `out_pc` = target.
  - Redirect-to-use = 2 cycles.
- Sustained throughput: 1 instruction per cycle while `out_ready` = 1 and `fetch_enable` = 1. Because a full queue blocks the push, DEPTH ≥ 2 is required to avoid bubbles.
- `misaligned` rises the cycle after the offending redirect edge.

## Test plan
- Reset, RESET_PC = 0x100, memory word k = 0xA000_0000+k, `out_ready` = 1 → successive accepted pairs (0x100, 0xA000_0040), (0x104, 0xA000_0041), (0x108, 0xA000_0042), …, one per cycle; `imem_address` = 0x40, 0x41, 0x42.
- `out_ready` = 0 for 5 cycles from reset → count saturates at 2 with pc = 0x108. Then `out_ready` = 1 → heads 0x100, 0x104, 0x108 delivered in order with no duplicate and no skip.
- Queue holding 0x100/0x104, redirect to 0x200 while `out_ready` = 1 → the next cycle has `out_valid` = 0; the cycle after has `out_pc` = 0x200; 0x104 never appears.
- Redirect to 0x202 → `misaligned` = 1, `out_valid` = 0, pc frozen. A later redirect to 0x300 is ignored. Reset clears the error and fetch restarts at RESET_PC.
- pc = 0xFFFF_FFFC, `fetch_enable` = 1 → entry 0xFFFF_FFFC is pushed and the next entry has `out_pc` = 0x0000_0000.
- `fetch_enable` = 0 for 3 cycles mid-stream → no pushes and pc stable; the queue drains to `out_valid` = 0; on re-enable, fetch resumes at the held pc.
